cas_fsk_player: RTL and testbench



---
 rtl/cas_pkg.sv | 22 ++
 rtl/cas_half_timer.sv | 27 ++
 rtl/cas_fsk_player.sv | 138 +++++++++++++
 tb/tb_cas_fsk_player.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_pkg.sv
// Shared types and defaults for the MC-10 cassette FSK playback source.
package cas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        BIT_HI = 2'd2,
        BIT_LO = 2'd3
    } cas_state_e;

    localparam int unsigned CAS_HALF_1 = 745;
    localparam int unsigned CAS_HALF_0 = 1491;
    localparam int unsigned CAS_CW     = 12;

    // Half-period length for a data bit: short half for '1', long half for '0'.
    function automatic int unsigned half_for(input logic b,
                                             input int unsigned half_1,
                                             input int unsigned half_0);
        return b ? half_1 : half_0;
    endfunction

endpackage

// File: rtl/cas_half_timer.sv
// Loadable down-counter timing one FSK half-period; expire marks the last clock of it.
module cas_half_timer #(
    parameter int unsigned CW = 12
) (
    input  logic          clk_4,
    input  logic          RESET,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          expire
);

    logic [CW-1:0] count;

    always_ff @(posedge clk_4 or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expire = (count == CW'(1));

endmodule

// File: rtl/cas_fsk_player.sv
// Serialises tape bytes LSB-first as MC-10 FSK audio on cin (2400 Hz cycle = '1', 1200 Hz cycle = '0').
module cas_fsk_player
    import cas_pkg::*;
#(
    parameter int unsigned HALF_1 = CAS_HALF_1,
    parameter int unsigned HALF_0 = CAS_HALF_0,
    parameter int unsigned CW     = CAS_CW
) (
    input  logic       clk_4,
    input  logic       RESET,
    input  logic       play,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       cin,
    output logic       busy,
    output cas_state_e state
);

    // Handshake: a byte transfers on a clock where byte_valid & byte_ready are both high;
    // byte_ready is held for the whole FETCH state and byte_data is ignored at all other times.

    if (HALF_1 < 1 || HALF_1 > (2**CW) - 1 || HALF_0 < 1 || HALF_0 > (2**CW) - 1) begin : g_bad_half
        $error("cas_fsk_player: HALF_1/HALF_0 must lie in 1..2**CW-1");
    end

    logic [7:0]    shreg;
    logic [2:0]    bitcnt;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_en;
    logic          expire;

    // Timer reloads at the start of every half; after a shift the next bit is shreg[1].
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            FETCH: begin
                if (play && byte_valid) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(half_for(byte_data[0], HALF_1, HALF_0));
                end
            end
            BIT_HI: begin
                if (expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(half_for(shreg[0], HALF_1, HALF_0));
                end
            end
            BIT_LO: begin
                if (expire && bitcnt != 3'd7) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(half_for(shreg[1], HALF_1, HALF_0));
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    assign tmr_en = (state == BIT_HI) || (state == BIT_LO);

    cas_half_timer #(.CW(CW)) u_timer (
        .clk_4    (clk_4),
        .RESET    (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (expire)
    );

    always_ff @(posedge clk_4 or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cin        <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (play) begin
                        state      <= FETCH;
                        byte_ready <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!play) begin
                        state      <= IDLE;
                        byte_ready <= 1'b0;
                    end else if (byte_valid) begin
                        state      <= BIT_HI;
                        byte_ready <= 1'b0;
                        shreg      <= byte_data;
                        bitcnt     <= 3'd0;
                        cin        <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                BIT_HI: begin
                    if (expire) begin
                        state <= BIT_LO;
                        cin   <= 1'b0;
                    end
                end
                BIT_LO: begin
                    if (expire) begin
                        if (bitcnt != 3'd7) begin
                            state  <= BIT_HI;
                            shreg  <= shreg >> 1;
                            bitcnt <= bitcnt + 3'd1;
                            cin    <= 1'b1;
                        end else begin
                            // play is only looked at here, so bytes are never cut short.
                            busy <= 1'b0;
                            if (play) begin
                                state      <= FETCH;
                                byte_ready <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    cin        <= 1'b0;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cas_fsk_player.sv
// Bench for cas_fsk_player: waveform-queue model checked every cycle plus literal run-length checks.
module tb_cas_fsk_player;
    import cas_pkg::*;

    localparam int unsigned H1 = 3;
    localparam int unsigned H0 = 6;

    logic       clk_4 = 1'b0;
    logic       RESET;
    logic       play, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, cin, busy;
    cas_state_e state;

    logic       play_d, valid_d;
    logic [7:0] data_d;
    logic       ready_d, cin_d, busy_d;
    cas_state_e state_d;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_4 = ~clk_4;

    cas_fsk_player #(.HALF_1(H1), .HALF_0(H0), .CW(12)) dut (
        .clk_4      (clk_4),
        .RESET      (RESET),
        .play       (play),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .cin        (cin),
        .busy       (busy),
        .state      (state)
    );

    cas_fsk_player u_def (
        .clk_4      (clk_4),
        .RESET      (RESET),
        .play       (play_d),
        .byte_data  (data_d),
        .byte_valid (valid_d),
        .byte_ready (ready_d),
        .cin        (cin_d),
        .busy       (busy_d),
        .state      (state_d)
    );

    // Model: an accepted byte becomes a queue of expected cin samples, one per clock.
    typedef enum {M_IDLE, M_FETCH, M_PLAY} mphase_e;
    mphase_e mp = M_IDLE;
    logic exp_q[$];
    logic m_cin = 1'b0, m_ready = 1'b0, m_busy = 1'b0;

    initial forever begin
        @(posedge clk_4 or posedge RESET);
        if (RESET) begin
            mp = M_IDLE;
            exp_q.delete();
        end else begin
            case (mp)
                M_IDLE:  if (play) mp = M_FETCH;
                M_FETCH: begin
                    if (!play) mp = M_IDLE;
                    else if (byte_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            int h;
                            h = byte_data[i] ? H1 : H0;
                            repeat (h) exp_q.push_back(1'b1);
                            repeat (h) exp_q.push_back(1'b0);
                        end
                        mp = M_PLAY;
                    end
                end
                M_PLAY: begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) mp = play ? M_FETCH : M_IDLE;
                end
                default: mp = M_IDLE;
            endcase
        end
        m_ready = (mp == M_FETCH);
        m_busy  = (mp == M_PLAY);
        m_cin   = (mp == M_PLAY) ? exp_q[0] : 1'b0;
    end

    always @(negedge clk_4) begin
        n_vec++;
        if (cin !== m_cin || byte_ready !== m_ready || busy !== m_busy) begin
            n_err++;
            $display("FAIL model_cmp @%0t: cin/ready/busy got %b%b%b, expected %b%b%b",
                     $time, cin, byte_ready, busy, m_cin, m_ready, m_busy);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
        end
    endtask

    logic cap_cin[$], cap_ready[$], cap_busy[$];

    task automatic clear_cap();
        cap_cin.delete();
        cap_ready.delete();
        cap_busy.delete();
    endtask

    // Called at a falling edge; samples n cycles and returns at the next falling edge.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_cin.push_back(cin);
            cap_ready.push_back(byte_ready);
            cap_busy.push_back(busy);
            @(negedge clk_4);
        end
    endtask

    function automatic int ones(input logic q[$], input int from, input int upto);
        int c = 0;
        for (int i = from; i < upto && i < q.size(); i++) if (q[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic string hi_runs(input logic q[$]);
        string s = "";
        int r = 0;
        foreach (q[i]) begin
            if (q[i] === 1'b1) r++;
            else if (r != 0) begin
                s = (s == "") ? $sformatf("%0d", r) : $sformatf("%s,%0d", s, r);
                r = 0;
            end
        end
        if (r != 0) s = (s == "") ? $sformatf("%0d", r) : $sformatf("%s,%0d", s, r);
        return s;
    endfunction

    // Presents a byte and waits for its transfer; returns at the falling edge of the first bit clock.
    task automatic send(input logic [7:0] b, input bit hold, output int waited);
        int i;
        byte_data  = b;
        byte_valid = 1'b1;
        for (i = 0; i < 3000 && byte_ready !== 1'b1; i++) @(negedge clk_4);
        waited = i;
        check("send_ready_seen", byte_ready, 1);
        @(posedge clk_4);
        @(negedge clk_4);
        if (!hold) byte_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, hi, lo;
        RESET = 1'b1; play = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        play_d = 1'b0; valid_d = 1'b0; data_d = 8'h00;
        repeat (2) @(negedge clk_4);
        check("rst_cin", cin, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state, IDLE);
        RESET = 1'b0;
        @(negedge clk_4);

        // 0xFF from IDLE: accepted on the first FETCH cycle.
        play = 1'b1;
        send(8'hFF, 1'b0, w);
        check("ff_wait_cycles", w, 1);
        clear_cap(); capture(49);
        check_str("ff_runs", hi_runs(cap_cin), "3,3,3,3,3,3,3,3");
        check("ff_cin_ones", ones(cap_cin, 0, 49), 24);
        check("ff_busy_cycles", ones(cap_busy, 0, 48), 48);
        check("ff_busy_end", cap_busy[48], 0);
        check("ff_ready_during", ones(cap_ready, 0, 48), 0);
        check("ff_ready_49", cap_ready[48], 1);

        send(8'h00, 1'b0, w);
        clear_cap(); capture(97);
        check_str("00_runs", hi_runs(cap_cin), "6,6,6,6,6,6,6,6");
        check("00_busy_cycles", ones(cap_busy, 0, 97), 96);
        check("00_ready_end", cap_ready[96], 1);

        send(8'hA5, 1'b0, w);
        clear_cap(); capture(73);
        check_str("a5_runs", hi_runs(cap_cin), "3,6,3,6,6,3,6,3");
        check("a5_busy_cycles", ones(cap_busy, 0, 73), 72);

        // Back-to-back with valid held: one FETCH low clock between bytes.
        send(8'h55, 1'b1, w);
        byte_data = 8'hAA;
        clear_cap(); capture(73);
        byte_valid = 1'b0;
        capture(73);
        check_str("b2b_runs", hi_runs(cap_cin), "3,6,3,6,3,6,3,6,6,3,6,3,6,3,6,3");
        check("b2b_busy_first", ones(cap_busy, 0, 73), 72);
        check("b2b_busy_total", ones(cap_busy, 0, 146), 144);
        check("b2b_gap_busy", cap_busy[72], 0);
        check("b2b_gap_ready", cap_ready[72], 1);
        check("b2b_gap_cin", cap_cin[72], 0);
        check("b2b_second_hi", cap_cin[73], 1);
        check("b2b_ready_end", cap_ready[145], 1);

        // play dropped during bit 2: byte still completes, then IDLE with a byte pending.
        send(8'h0F, 1'b0, w);
        clear_cap(); capture(14);
        play = 1'b0; byte_data = 8'h33; byte_valid = 1'b1;
        capture(78);
        check_str("0f_runs", hi_runs(cap_cin), "3,3,3,3,6,6,6,6");
        check("0f_busy_cycles", ones(cap_busy, 0, 92), 72);
        check("0f_last_bit_busy", cap_busy[71], 1);
        check("0f_ready_never", ones(cap_ready, 0, 92), 0);
        check("0f_idle_state", state, IDLE);

        // Tape gap: FETCH with nothing to send.
        byte_valid = 1'b0; play = 1'b1;
        @(negedge clk_4);
        clear_cap(); capture(500);
        check("gap_ready", ones(cap_ready, 0, 500), 500);
        check("gap_cin", ones(cap_cin, 0, 500), 0);
        check("gap_busy", ones(cap_busy, 0, 500), 0);

        // Asynchronous reset in the middle of a high half.
        send(8'hFF, 1'b0, w);
        clear_cap(); capture(2);
        check("pre_reset_cin", cin, 1);
        #2 RESET = 1'b1;
        #1;
        check("async_rst_cin", cin, 0);
        check("async_rst_ready", byte_ready, 0);
        check("async_rst_busy", busy, 0);
        play = 1'b0;
        @(negedge clk_4);
        RESET = 1'b0;
        clear_cap(); capture(100);
        check("idle100_cin", ones(cap_cin, 0, 100), 0);
        check("idle100_ready", ones(cap_ready, 0, 100), 0);
        check("idle100_busy", ones(cap_busy, 0, 100), 0);
        check("idle100_state", state, IDLE);

        // Default timing: a single '1' bit is 745 clocks high then 745 low.
        data_d = 8'h01; valid_d = 1'b1; play_d = 1'b1;
        for (int i = 0; i < 10 && ready_d !== 1'b1; i++) @(negedge clk_4);
        check("def_ready", ready_d, 1);
        @(posedge clk_4);
        @(negedge clk_4);
        valid_d = 1'b0; play_d = 1'b0;
        hi = 0;
        while (cin_d === 1'b1 && hi < 2000) begin hi++; @(negedge clk_4); end
        lo = 0;
        while (cin_d === 1'b0 && lo < 2000) begin lo++; @(negedge clk_4); end
        check("def_hi_half", hi, 745);
        check("def_lo_half", lo, 745);
        check("def_busy", busy_d, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
